// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshake, issue reservation, source queries, RF write port.
interface rf_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [2:0]          REQ_VALID;
    logic [2:0]          REQ_READY;
    logic [3*ADDR_W-1:0] REQ_ADDR;
    logic [3*DATA_W-1:0] REQ_DATA;
    logic                ISSUE_VALID;
    logic [ADDR_W-1:0]   ISSUE_ADDR;
    logic                ISSUE_READY;
    logic [ADDR_W-1:0]   RS1_ADDR;
    logic [ADDR_W-1:0]   RS2_ADDR;
    logic                RS1_BUSY;
    logic                RS2_BUSY;
    logic                WRITE_ENABLE;
    logic [ADDR_W-1:0]   WRITE_ADDRESS;
    logic [DATA_W-1:0]   WRITE_DATA;

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_DATA, ISSUE_VALID, ISSUE_ADDR, RS1_ADDR, RS2_ADDR,
        input  REQ_READY, ISSUE_READY, RS1_BUSY, RS2_BUSY,
               WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA
    );

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, ISSUE_VALID, ISSUE_ADDR, RS1_ADDR, RS2_ADDR,
        output REQ_READY, ISSUE_READY, RS1_BUSY, RS2_BUSY,
               WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin over ALU/load/muldiv requesters,
// one-cycle registered write port, and a pending-write scoreboard for WAW/RAW checks.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    rf_wb_arbiter_if.slave   bus
);
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned NUM_REG = 1 << ADDR_W;
    localparam int unsigned PTR_W   = 2;

    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [NUM_REG-1:0] pending;
    logic [NUM_REG-1:0] pending_nxt;
    logic               issue_fire;
    logic               we_q;
    logic [ADDR_W-1:0]  wa_q;
    logic [DATA_W-1:0]  wd_q;

    // Round-robin grant starting at ptr; forced idle while reset is asserted.
    always_comb begin
        grant = '0;
        if (RST_N) begin
            case (ptr)
                2'd1: begin
                    if      (bus.REQ_VALID[1]) grant = 3'b010;
                    else if (bus.REQ_VALID[2]) grant = 3'b100;
                    else if (bus.REQ_VALID[0]) grant = 3'b001;
                end
                2'd2: begin
                    if      (bus.REQ_VALID[2]) grant = 3'b100;
                    else if (bus.REQ_VALID[0]) grant = 3'b001;
                    else if (bus.REQ_VALID[1]) grant = 3'b010;
                end
                default: begin
                    if      (bus.REQ_VALID[0]) grant = 3'b001;
                    else if (bus.REQ_VALID[1]) grant = 3'b010;
                    else if (bus.REQ_VALID[2]) grant = 3'b100;
                end
            endcase
        end
    end

    assign xfer          = |grant;
    assign bus.REQ_READY = grant;

    // Mux the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_addr = bus.REQ_ADDR[i*ADDR_W +: ADDR_W];
                sel_data = bus.REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Scoreboard lookups; register 0 is never pending.
    assign bus.ISSUE_READY = RST_N && ((bus.ISSUE_ADDR == '0) || !pending[bus.ISSUE_ADDR]);
    assign issue_fire      = bus.ISSUE_VALID && bus.ISSUE_READY && (bus.ISSUE_ADDR != '0);
    assign bus.RS1_BUSY    = pending[bus.RS1_ADDR];
    assign bus.RS2_BUSY    = pending[bus.RS2_ADDR];

    // Next pending vector: clear on write, then set on issue so a same-edge set wins.
    always_comb begin
        pending_nxt = pending;
        if (we_q) begin
            pending_nxt[wa_q] = 1'b0;
        end
        if (issue_fire) begin
            pending_nxt[bus.ISSUE_ADDR] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Pointer, write port and scoreboard state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr     <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            pending <= '0;
        end else begin
            pending <= pending_nxt;
            we_q    <= xfer && (sel_addr != '0);
            if (xfer) begin
                wa_q <= sel_addr;
                wd_q <= sel_data;
                case (grant)
                    3'b001:  ptr <= PTR_W'(1);
                    3'b010:  ptr <= PTR_W'(2);
                    default: ptr <= PTR_W'(0);
                endcase
            end
        end
    end

    assign bus.WRITE_ENABLE  = we_q;
    assign bus.WRITE_ADDRESS = wa_q;
    assign bus.WRITE_DATA    = wd_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: per-cycle vector table for grants/busy flags plus a
// write-port scoreboard queue filled from the table and drained on the following cycle.
module tb_rf_wb_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int NVEC = 15;

    logic CLK;
    logic RST_N;

    rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  rs1, rs2;
        logic [2:0]  er;
        logic        eir, eb1, eb2;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t tbl [NVEC];
    wr_t  sbq [$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic [2:0] valid, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] d, logic iv, logic [4:0] ia, logic [4:0] rs1,
                                logic [4:0] rs2, logic [2:0] er, logic eir, logic eb1, logic eb2);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.d = d;
        v.iv = iv; v.ia = ia; v.rs1 = rs1; v.rs2 = rs2;
        v.er = er; v.eir = eir; v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    // Requesters 0 and 1 carry d, requester 2 carries ~d.
    function automatic logic [31:0] dat_of(vec_t v, int i);
        return (i == 2) ? ~v.d : v.d;
    endfunction

    function automatic logic [4:0] addr_of(vec_t v, int i);
        return (i == 0) ? v.a0 : ((i == 1) ? v.a1 : v.a2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        bus.REQ_VALID   = v.valid;
        bus.REQ_ADDR    = {v.a2, v.a1, v.a0};
        bus.REQ_DATA    = {dat_of(v, 2), dat_of(v, 1), dat_of(v, 0)};
        bus.ISSUE_VALID = v.iv;
        bus.ISSUE_ADDR  = v.ia;
        bus.RS1_ADDR    = v.rs1;
        bus.RS2_ADDR    = v.rs2;
    endtask

    // One cycle: drive at negedge, check combinational outputs, queue the expected write.
    task automatic step(input vec_t v, input string tag);
        wr_t w;
        @(negedge CLK);
        drive(v);
        #1;
        chk({tag, " ready"},  32'(bus.REQ_READY),   32'(v.er));
        chk({tag, " iready"}, 32'(bus.ISSUE_READY), 32'(v.eir));
        chk({tag, " busy1"},  32'(bus.RS1_BUSY),    32'(v.eb1));
        chk({tag, " busy2"},  32'(bus.RS2_BUSY),    32'(v.eb2));
        @(posedge CLK);
        w.we = 1'b0; w.a = '0; w.d = '0;
        for (int i = 0; i < 3; i++) begin
            if (v.er[i]) begin
                w.a  = addr_of(v, i);
                w.d  = dat_of(v, i);
                w.we = (w.a != 5'd0);
            end
        end
        sbq.push_back(w);
    endtask

    // Write-port monitor: one expected record per cycle after each stepped cycle.
    always @(negedge CLK) begin
        if (sbq.size() > 0) begin
            wr_t w;
            w = sbq.pop_front();
            chk("wr_en", 32'(bus.WRITE_ENABLE), 32'(w.we));
            if (w.we) begin
                chk("wr_addr", 32'(bus.WRITE_ADDRESS), 32'(w.a));
                chk("wr_data", bus.WRITE_DATA, w.d);
            end
        end
    end

    initial begin
        vec_t idle, v;
        idle = mk(3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0, 3'b000, 1, 0, 0);

        //              valid   a0 a1 a2 d              iv ia  rs1 rs2 er     eir eb1 eb2
        tbl[0]  = mk(3'b111, 1, 2, 3, 32'h1000_0000, 0, 0,  1,  2, 3'b001, 1, 0, 0);
        tbl[1]  = mk(3'b111, 1, 2, 3, 32'h1100_0000, 0, 0,  1,  2, 3'b010, 1, 0, 0);
        tbl[2]  = mk(3'b111, 1, 2, 3, 32'h1200_0000, 0, 0,  1,  2, 3'b100, 1, 0, 0);
        tbl[3]  = mk(3'b111, 1, 2, 3, 32'h1300_0000, 0, 0,  1,  2, 3'b001, 1, 0, 0);
        tbl[4]  = mk(3'b010, 0, 5, 0, 32'hDEAD_BEEF, 0, 0,  0,  5, 3'b010, 1, 0, 0);
        tbl[5]  = mk(3'b000, 0, 0, 0, 32'h0,         1, 7,  7,  5, 3'b000, 1, 0, 0);
        tbl[6]  = mk(3'b000, 0, 0, 0, 32'h0,         1, 7,  7,  0, 3'b000, 0, 1, 0);
        tbl[7]  = mk(3'b001, 7, 0, 0, 32'h7777_0001, 0, 0,  7,  0, 3'b001, 1, 1, 0);
        tbl[8]  = mk(3'b000, 0, 0, 0, 32'h0,         0, 0,  7,  9, 3'b000, 1, 1, 0);
        tbl[9]  = mk(3'b100, 0, 0, 9, 32'h9999_0002, 0, 0,  7,  9, 3'b100, 1, 0, 0);
        tbl[10] = mk(3'b000, 0, 0, 0, 32'h0,         1, 9,  7,  9, 3'b000, 1, 0, 0);
        tbl[11] = mk(3'b001, 0, 0, 0, 32'h0000_0001, 1, 0,  0,  9, 3'b001, 1, 0, 1);
        tbl[12] = mk(3'b110, 0, 4, 6, 32'h4646_0003, 1, 3,  0,  9, 3'b010, 1, 0, 1);
        tbl[13] = mk(3'b110, 0, 4, 6, 32'h4646_0004, 1, 12, 3,  9, 3'b100, 1, 1, 1);
        tbl[14] = mk(3'b000, 0, 0, 0, 32'h0,         0, 0,  12, 3, 3'b000, 1, 1, 1);

        // Reset state with requests present.
        RST_N = 1'b0;
        drive(mk(3'b111, 1, 2, 3, 32'h5, 1, 4, 4, 0, 3'b000, 0, 0, 0));
        #2;
        chk("rst ready",  32'(bus.REQ_READY),     32'd0);
        chk("rst iready", 32'(bus.ISSUE_READY),   32'd0);
        chk("rst we",     32'(bus.WRITE_ENABLE),  32'd0);
        chk("rst waddr",  32'(bus.WRITE_ADDRESS), 32'd0);
        chk("rst wdata",  bus.WRITE_DATA,         32'd0);
        drive(idle);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int k = 0; k < NVEC; k++) begin
            step(tbl[k], $sformatf("vec%0d", k));
        end

        // Reset mid-cycle while a write is on the port and 3, 9, 12 are pending.
        step(mk(3'b001, 15, 0, 0, 32'hF00D_0015, 0, 0, 3, 9, 3'b001, 1, 1, 1), "pre_rst");
        @(negedge CLK);
        #2;
        chk("pre_rst we", 32'(bus.WRITE_ENABLE), 32'd1);
        drive(mk(3'b111, 1, 2, 3, 32'h0, 1, 20, 3, 9, 3'b000, 0, 0, 0));
        RST_N = 1'b0;
        #1;
        sbq.delete();
        chk("mid_rst we",     32'(bus.WRITE_ENABLE),  32'd0);
        chk("mid_rst waddr",  32'(bus.WRITE_ADDRESS), 32'd0);
        chk("mid_rst wdata",  bus.WRITE_DATA,         32'd0);
        chk("mid_rst busy1",  32'(bus.RS1_BUSY),      32'd0);
        chk("mid_rst busy2",  32'(bus.RS2_BUSY),      32'd0);
        chk("mid_rst ready",  32'(bus.REQ_READY),     32'd0);
        chk("mid_rst iready", 32'(bus.ISSUE_READY),   32'd0);
        @(posedge CLK);
        @(negedge CLK);
        drive(idle);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;
        chk("post_rst we", 32'(bus.WRITE_ENABLE), 32'd0);

        // First arbitration after release favours requester 0; pending bits are gone.
        step(mk(3'b111, 1, 2, 3, 32'hABCD_0001, 0, 0, 3, 9, 3'b001, 1, 0, 0), "post_rst0");
        step(mk(3'b000, 0, 0, 0, 32'h0, 1, 12, 12, 0, 3'b000, 1, 0, 0), "post_rst1");
        step(idle, "drain");
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("sb empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ_VALID  input  3  per-requester writeback request (bit0 ALU, bit1 load, bit2 mul/div).
REQ-006 REQ_READY  output  3  per-requester grant; transfer occurs when REQ_VALID[i] and REQ_READY[i] are both high at a clock edge.
REQ-007 REQ_ADDR  input  3*ADDR_W  destination register; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 REQ_DATA  input  3*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 ISSUE_VALID  input  1  issue stage reserves a destination register.
REQ-010 ISSUE_ADDR  input  ADDR_W  register to reserve.
REQ-011 ISSUE_READY  output  1  reservation accepted; low when ISSUE_ADDR is already pending (WAW).
REQ-012 RS1_ADDR, RS2_ADDR  input  ADDR_W each  source registers being queried.
REQ-013 RS1_BUSY, RS2_BUSY  output  1 each  queried register has a pending write.
REQ-014 WRITE_ENABLE  output  1  register-file write strobe.
REQ-015 WRITE_ADDRESS  output  ADDR_W  register-file write address.
REQ-016 WRITE_DATA  output  DATA_W  register-file write data.

Function
REQ-017 Arbitration SHALL be round-robin over asserted REQ_VALID bits, searching from priority pointer PTR upward modulo 3.
REQ-018 At most one REQ_READY bit SHALL be high per cycle; REQ_READY is combinational from REQ_VALID and PTR; REQ_READY[i] SHALL never be high while REQ_VALID[i] is low.
REQ-019 On a transfer by requester i, PTR SHALL become (i+1) mod 3 at that edge; with no transfer PTR SHALL hold.
REQ-020 Requesters hold ADDR/DATA stable while VALID is high and not granted; the block does not buffer ungranted requests.
REQ-021 Write-port latency SHALL be exactly one cycle: a transfer at edge N drives WRITE_ENABLE/WRITE_ADDRESS/WRITE_DATA registered during cycle N to N+1; the register file writes at edge N+1.
REQ-022 Cycles with no transfer SHALL drive WRITE_ENABLE=0; WRITE_ADDRESS/WRITE_DATA hold their previous values.
REQ-023 A transfer with address 0 SHALL be accepted (READY high, PTR advances) but produce WRITE_ENABLE=0.
REQ-024 Scoreboard: 32 pending bits; bit 0 SHALL be constant 0.
REQ-025 ISSUE_READY = !pending[ISSUE_ADDR], or 1 when ISSUE_ADDR=0; combinational.
REQ-026 ISSUE_VALID && ISSUE_READY at an edge with ISSUE_ADDR!=0 SHALL set pending[ISSUE_ADDR].
REQ-027 WRITE_ENABLE high at an edge SHALL clear pending[WRITE_ADDRESS] at that edge.
REQ-028 Simultaneous set and clear of the same address at one edge: set wins (bit remains 1).
REQ-029 RSx_BUSY = pending[RSx_ADDR], combinational; RSx_ADDR=0 gives 0; a register being written in the current cycle still reads busy (no bypass).
REQ-030 Write to a non-pending register SHALL still be performed; pending bit stays 0.

Reset
REQ-031 RST_N low SHALL immediately force WRITE_ENABLE=0, WRITE_ADDRESS=0, WRITE_DATA=0, all pending bits=0, PTR=0, independent of CLK.
REQ-032 During reset REQ_READY SHALL be all 0 and ISSUE_READY SHALL be 0.
REQ-033 A transfer in flight when reset asserts SHALL be discarded; no write follows reset release.
REQ-034 First arbitration after reset release SHALL favour requester 0.

Verification
REQ-035 Reset, then REQ_VALID=3'b111 held 4 cycles -> grants 0,1,2,0 on consecutive cycles; WRITE_ENABLE high for 4 cycles, one cycle after each grant.
REQ-036 REQ_VALID[1]=1, addr 5, data 0xDEADBEEF -> REQ_READY=3'b010 same cycle; next cycle WRITE_ENABLE=1, WRITE_ADDRESS=5, WRITE_DATA=0xDEADBEEF; following cycle WRITE_ENABLE=0.
REQ-037 Issue addr 7 -> RS1_ADDR=7 gives RS1_BUSY=1; a second issue of 7 sees ISSUE_READY=0; ALU write to 7 -> RS1_BUSY=1 during the WRITE_ENABLE cycle, 0 the cycle after.
REQ-038 Same edge: issue addr 9 and WRITE_ENABLE to 9 -> pending[9] stays 1.
REQ-039 Request to addr 0 with data 0x1 -> REQ_READY high, WRITE_ENABLE stays 0; issue to addr 0 -> ISSUE_READY=1, RS1_BUSY(0)=0.
REQ-040 Assert RST_N low mid-cycle while WRITE_ENABLE=1 and three registers pending -> WRITE_ENABLE drops without a clock edge, all BUSY=0, PTR=0 after release.
